// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings and the bit-period rounding
// helper. The receive side imports the same package.
package uart_defs;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Clocks per bit, rounded to nearest.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Writes are dropped when full, reads when empty.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Pointer update, wrapping naturally through the extra MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/debug_uart_tx.sv
// Byte-stream UART transmitter: valid/ready byte port into a FIFO, 8N1-style
// LSB-first frames, back-to-back with no idle gap.
// Optional parity bit is compiled in with `UART_TX_PARITY_EN.
module debug_uart_tx
   import uart_defs::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int             CPB      = clks_per_bit(CLK_HZ, BAUD);
   localparam int             TW       = $clog2(CPB);
   localparam logic [TW-1:0]  BIT_LAST = TW'(CPB - 1);
   localparam logic           STOP_LST = 1'(STOP_BITS - 1);

   // Reject configurations the timer and stop counter cannot represent.
   if (CPB < 4 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("debug_uart_tx: unsupported parameter set");
   end

   uart_state_t   state;
   uart_state_t   state_nxt;
   logic [TW-1:0] timer;
   logic [2:0]    bit_cnt;
   logic          stop_cnt;
   logic [7:0]    shreg;
   logic          bit_done;
   logic          last_stop;
   logic          pop;
   logic          tx_nxt;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
`ifdef UART_TX_PARITY_EN
   logic          par_bit;
`endif

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (din_valid),
      .din   (din),
      .rd_en (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Ready follows the registered pointers only, so a pop never re-opens it
   // in the same cycle the FIFO is full.
   assign din_ready = !fifo_full;

   assign bit_done  = (timer == '0);
   assign last_stop = (stop_cnt == STOP_LST);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state: frames chain STOP -> START directly when more data waits.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (!fifo_empty) state_nxt = ST_START;
         ST_START:  if (bit_done) state_nxt = ST_DATA;
`ifdef UART_TX_PARITY_EN
         ST_DATA:   if (bit_done && bit_cnt == 3'd7) state_nxt = ST_PARITY;
         ST_PARITY: if (bit_done) state_nxt = ST_STOP;
`else
         ST_DATA:   if (bit_done && bit_cnt == 3'd7) state_nxt = ST_STOP;
`endif
         ST_STOP:   if (bit_done && last_stop) state_nxt = fifo_empty ? ST_IDLE : ST_START;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: FIFO pop and the line level for the current bit.
   always_comb begin
      pop    = !fifo_empty && ((state == ST_IDLE) ||
                               (state == ST_STOP && bit_done && last_stop));
      tx_nxt = 1'b1;
      case (state)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_nxt = par_bit;
`endif
         default:   tx_nxt = 1'b1;
      endcase
   end

   // Bit timer, bit/stop counters and shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer    <= BIT_LAST;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         // Timer rests loaded in IDLE so START gets a full bit period.
         timer <= (state == ST_IDLE || bit_done) ? BIT_LAST : timer - 1'b1;

         if (pop)                              shreg <= fifo_dout;
         else if (state == ST_DATA && bit_done) shreg <= {1'b0, shreg[7:1]};

`ifdef UART_TX_PARITY_EN
         if (pop) par_bit <= (^fifo_dout) ^ 1'(PARITY_ODD);
`endif

         if (state != ST_DATA) bit_cnt <= '0;
         else if (bit_done)    bit_cnt <= bit_cnt + 1'b1;

         if (state != ST_STOP) stop_cnt <= 1'b0;
         else if (bit_done)    stop_cnt <= stop_cnt + 1'b1;
      end
   end

   // Registered line and busy; busy is aligned with the registered tx so it
   // drops the cycle after the last stop clock leaves the pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx   <= 1'b1;
         busy <= 1'b0;
      end else begin
         tx   <= tx_nxt;
         busy <= (state != ST_IDLE) || (fifo_level != '0);
      end
   end

endmodule
